// File: rtl/seq_pattern_tx_pkg.sv
// rtl/seq_pattern_tx_pkg.sv - shared state type and default constants for seq_pattern_tx
package seq_pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_GAP_LEN = 2;
    localparam int DEF_RPT_W   = 4;

    localparam logic [3:0] TEST_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_pattern_tx_piso.sv
// rtl/seq_pattern_tx_piso.sv - parallel-load, shift-left, MSB-out register
module piso_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] sr_q;

    // Load wins over shift so a frame reload on the last bit is never lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial MSB-first pattern transmitter; SEQ_PATTERN_TX_REPEAT_EN adds repeats and gaps
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
`ifdef SEQ_PATTERN_TX_REPEAT_EN
    ,
    parameter int GAP_LEN = DEF_GAP_LEN,
    parameter int RPT_W   = DEF_RPT_W
`endif
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [WIDTH-1:0] pattern_i,
`ifdef SEQ_PATTERN_TX_REPEAT_EN
    input  logic [RPT_W-1:0] repeat_i,
`endif
    output logic             dout_o,
    output logic             dout_valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    state_e          state_q;
    logic [CW-1:0]   bit_cnt_q;
    logic            start_ready_q;
    logic            busy_q;
    logic            done_q;
    logic            dout_valid_q;

    logic             hs;
    logic             sr_load;
    logic             sr_shift;
    logic [WIDTH-1:0] sr_data;
    logic             sr_msb;

`ifdef SEQ_PATTERN_TX_REPEAT_EN
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [GW-1:0] GAP_MAX = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    logic [RPT_W-1:0] rpt_q;
    logic [GW-1:0]    gap_cnt_q;
    logic [WIDTH-1:0] pattern_q;
`endif

    assign hs = start_valid_i & start_ready_q;

    always_comb begin
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_data  = pattern_i;
        if (hs) begin
            sr_load = 1'b1;
        end else if (state_q == ST_SEND) begin
            sr_shift = 1'b1;
`ifdef SEQ_PATTERN_TX_REPEAT_EN
            // Reload from the latched word, not the live input, for repeats.
            if (bit_cnt_q == '0 && rpt_q != '0) begin
                sr_load = 1'b1;
                sr_data = pattern_q;
            end
`endif
        end
    end

    piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .data_i  (sr_data),
        .msb_o   (sr_msb)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            dout_valid_q  <= 1'b0;
`ifdef SEQ_PATTERN_TX_REPEAT_EN
            rpt_q         <= '0;
            gap_cnt_q     <= '0;
            pattern_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (hs) begin
                        state_q       <= ST_SEND;
                        bit_cnt_q     <= CNT_MAX;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        dout_valid_q  <= 1'b1;
`ifdef SEQ_PATTERN_TX_REPEAT_EN
                        rpt_q         <= repeat_i;
                        pattern_q     <= pattern_i;
`endif
                    end
                end
                ST_SEND: begin
                    if (bit_cnt_q != '0) begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
`ifdef SEQ_PATTERN_TX_REPEAT_EN
                    end else if (rpt_q != '0) begin
                        rpt_q     <= rpt_q - 1'b1;
                        bit_cnt_q <= CNT_MAX;
                        if (GAP_LEN > 0) begin
                            state_q      <= ST_GAP;
                            gap_cnt_q    <= GAP_MAX;
                            dout_valid_q <= 1'b0;
                        end
`endif
                    end else begin
                        state_q      <= ST_DONE;
                        dout_valid_q <= 1'b0;
                        done_q       <= 1'b1;
                    end
                end
`ifdef SEQ_PATTERN_TX_REPEAT_EN
                ST_GAP: begin
                    gap_cnt_q <= gap_cnt_q - 1'b1;
                    if (gap_cnt_q == '0) begin
                        state_q      <= ST_SEND;
                        dout_valid_q <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    state_q       <= ST_IDLE;
                    busy_q        <= 1'b0;
                    start_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_ready_o = start_ready_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign dout_valid_o  = dout_valid_q;
    assign dout_o        = dout_valid_q & sr_msb;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed self-checking bench for seq_pattern_tx
module tb_seq_pattern_tx;
    import seq_pattern_tx_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic [W-1:0] pattern = '0;
`ifdef SEQ_PATTERN_TX_REPEAT_EN
    logic [3:0]   rpt = '0;
`endif
    logic         start_ready;
    logic         dout;
    logic         dout_valid;
    logic         busy;
    logic         done;

    int checks = 0;
    int failures = 0;

    seq_pattern_tx #(.WIDTH(W)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_valid_i (start_valid),
        .start_ready_o (start_ready),
        .pattern_i     (pattern),
`ifdef SEQ_PATTERN_TX_REPEAT_EN
        .repeat_i      (rpt),
`endif
        .dout_o        (dout),
        .dout_valid_o  (dout_valid),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle of the first bit; returns in the cycle after the last bit.
    task automatic chk_frame(input string tag, input logic [3:0] p);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_dout"}, 32'(dout), 32'(p[3-i]));
            chk({tag, "_valid"}, 32'(dout_valid), 32'd1);
            tick();
        end
    endtask

    initial begin
        logic [3:0] p_a;
        logic [3:0] p_b;
        p_a = 4'b1101;
        p_b = 4'b0110;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_ready", 32'(start_ready), 32'd1);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Single frame of the canonical pattern.
        start_valid = 1'b1;
        pattern = TEST_PATTERN;
        tick();
        start_valid = 1'b0;
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_ready", 32'(start_ready), 32'd0);
        chk_frame("single", p_a);
        chk("single_done", 32'(done), 32'd1);
        chk("single_done_valid", 32'(dout_valid), 32'd0);
        chk("single_done_ready", 32'(start_ready), 32'd0);
        tick();
        chk("single_done_clr", 32'(done), 32'd0);
        chk("single_ready_back", 32'(start_ready), 32'd1);
        chk("single_busy_clr", 32'(busy), 32'd0);

        // Start_valid held through a frame; pattern changed mid-frame.
        start_valid = 1'b1;
        pattern = p_a;
        tick();
        chk("rej_b0", 32'(dout), 32'd1);
        tick();
        pattern = p_b;
        chk("rej_b1", 32'(dout), 32'd1);
        tick();
        chk("rej_b2", 32'(dout), 32'd0);
        tick();
        chk("rej_b3", 32'(dout), 32'd1);
        tick();
        chk("rej_done", 32'(done), 32'd1);
        chk("rej_ready5", 32'(start_ready), 32'd0);
        tick();
        chk("rej_ready6", 32'(start_ready), 32'd1);
        tick();
        start_valid = 1'b0;
        chk_frame("rej_next", p_b);
        chk("rej_next_done", 32'(done), 32'd1);
        tick();
        chk("rej_next_ready", 32'(start_ready), 32'd1);

        // Reset asserted in cycle 2 of a frame.
        start_valid = 1'b1;
        pattern = p_a;
        tick();
        start_valid = 1'b0;
        tick();
        chk("mid_valid_pre", 32'(dout_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_dout", 32'(dout), 32'd0);
        chk("mid_valid", 32'(dout_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ready", 32'(start_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("mid_no_done", 32'(done), 32'd0);
            chk("mid_idle_valid", 32'(dout_valid), 32'd0);
            tick();
        end
        chk("mid_ready_after", 32'(start_ready), 32'd1);

`ifdef SEQ_PATTERN_TX_REPEAT_EN
        begin
            logic [15:0] exp_d;
            logic [15:0] exp_v;
            int nbits;
            int ndone;
            int cyc;
            exp_d = 16'b1101001101001101;
            exp_v = 16'b1111001111001111;
            start_valid = 1'b1;
            pattern = p_a;
            rpt = 4'd2;
            tick();
            start_valid = 1'b0;
            pattern = p_b;
            rpt = 4'd0;
            for (int i = 0; i < 16; i++) begin
                chk("rpt_dout", 32'(dout), 32'(exp_d[15-i]));
                chk("rpt_valid", 32'(dout_valid), 32'(exp_v[15-i]));
                chk("rpt_nodone", 32'(done), 32'd0);
                tick();
            end
            chk("rpt_done", 32'(done), 32'd1);
            tick();
            chk("rpt_done_clr", 32'(done), 32'd0);
            chk("rpt_ready", 32'(start_ready), 32'd1);

            // Maximum repeat count: 16 frames of 4 bits.
            start_valid = 1'b1;
            pattern = p_a;
            rpt = 4'hF;
            tick();
            start_valid = 1'b0;
            nbits = 0;
            ndone = 0;
            cyc = 0;
            while (ndone == 0 && cyc < 200) begin
                if (dout_valid) nbits++;
                if (done) ndone++;
                tick();
                cyc++;
            end
            chk("rptmax_timeout", 32'(cyc < 200), 32'd1);
            chk("rptmax_bits", 32'(nbits), 32'd64);
            chk("rptmax_cycles", 32'(cyc), 32'd95);
        end
`else
        start_valid = 1'b1;
        pattern = 4'b1011;
        tick();
        start_valid = 1'b0;
        chk_frame("norpt", 4'b1011);
        chk("norpt_done", 32'(done), 32'd1);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("norpt_idle_valid", 32'(dout_valid), 32'd0);
            chk("norpt_idle_done", 32'(done), 32'd0);
            tick();
        end
        chk("norpt_ready", 32'(start_ready), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first on a single-bit line, one bit per clock. It drives the bit-stream input of the team's serial sequence detectors and serves as the stimulus source for serial-link and loopback tests. Outputs are Moore-style: every output is a function of registered state only.

## Interface
- WIDTH, 4: frame length in bits; legal range is 2 or more.
- GAP_LEN, 2: idle bit-times inserted between repeated frames; 0 means back-to-back.
- RPT_W, 4: width of the Repeat port. Used only when the repeat macro is defined.
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset. This is the only reset; the block uses one clock.
- Start_valid  in  1  request to send Pattern.
- Start_ready  out  1  high only in IDLE. A handshake completes when Start_valid and Start_ready are both high.
- Pattern  in  WIDTH  word to transmit. Sampled only at the handshake.
- Repeat  in  RPT_W  number of additional frame repetitions. Sampled at the handshake. Present only with the macro.
- Dout  out  1  serial data bit. 0 whenever Dout_valid is low.
- Dout_valid  out  1  high while a data bit is being driven.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse after the final bit of the final frame.

## Operation
- States: IDLE, SEND, GAP, DONE.
- Reset values: state is IDLE, Dout=0, Dout_valid=0, Busy=0, Done=0, Start_ready=1. Shift register, bit counter and repeat counter are all 0.
- IDLE
  - On handshake: load the shift register with Pattern, load the bit counter with WIDTH-1, latch Repeat, and go to SEND.
  - Without a handshake: stay in IDLE.
- SEND
  - Dout is the shift-register MSB and Dout_valid=1. Each cycle the register shifts left and fills with 0, and the bit counter decrements.
  - When the bit counter reaches 0:
    - If the repeat count is non-zero: decrement it, reload the shift register from the latched word, then go to GAP if GAP_LEN>0, otherwise back to SEND.
    - If the repeat count is zero: go to DONE.
- GAP
  - Dout=0, Dout_valid=0. Lasts exactly GAP_LEN cycles, then go to SEND with the bit counter at WIDTH-1.
- DONE
  - Done=1 and Start_ready=0 for one cycle, then go to IDLE.
- Boundary conditions:
  - Start_valid while Busy: ignored, not queued.
  - Changes to Pattern or Repeat after the handshake: no effect.
  - Repeat at its maximum value (2^RPT_W−1) sends 2^RPT_W frames; the repeat counter does not wrap.
  - Reset_n asserted mid-frame: all outputs take their reset values immediately (asynchronously). The frame is abandoned and Done is not pulsed.
- Bit counter width is $clog2(WIDTH). Repeat counter width is RPT_W.

## Timing
- Handshake at cycle t. First bit (Pattern[WIDTH-1]) appears on Dout at t+1. Bit i (MSB = 0) appears at t+1+i.
- Single frame:
  - Last bit at t+WIDTH.
  - Done at t+WIDTH+1.
  - Start_ready returns at t+WIDTH+2.
- Each repetition adds WIDTH+GAP_LEN cycles.
- Minimum spacing between handshakes is WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- SEQ_PATTERN_TX_REPEAT_EN:
  - Defined: the Repeat port, repeat counter and GAP state exist, and behaviour is as above.
  - Undefined: the Repeat port, repeat counter and GAP state are removed. Every handshake sends exactly one frame, then DONE. GAP_LEN and RPT_W are ignored.

## Structure
- Package seq_pattern_tx_pkg holds:
  - the typedef enum for the states IDLE, SEND, GAP, DONE (2-bit encoding);
  - default constants for WIDTH and GAP_LEN;
  - the canonical test pattern constant 4'b1101.
- One sub-module, piso_shift_reg: parallel-load, shift-left, MSB-out register with load and shift enables and the same asynchronous active-low reset.
- The FSM, bit counter and repeat counter stay in the top-level module.

## Test plan
- Reset: hold Reset_n=0 for 3 cycles, then release. Required: Start_ready=1 and Dout, Dout_valid, Busy, Done all 0.
- WIDTH=4, Pattern=4'b1101, handshake at cycle 0. Required:
  - Dout = 1,1,0,1 at cycles 1–4, with Dout_valid=1 throughout;
  - Done=1 at cycle 5;
  - Start_ready=1 at cycle 6.
- Repeat=2, GAP_LEN=2, Pattern=4'b1101. Required:
  - bit pattern 1101,00,1101,00,1101 over 16 cycles, with Dout_valid low only during the gaps;
  - a single Done pulse at cycle 17.
- Busy rejection: Start_valid held high throughout a frame, and Pattern changed to 4'b0110 at cycle 2. Required:
  - the current frame still sends 1101;
  - the next handshake occurs at cycle 6 and sends 0110.
- Reset mid-frame: assert Reset_n=0 at cycle 2 of a frame. Required:
  - Dout=0 and Dout_valid=0 immediately;
  - no Done pulse;
  - Start_ready=1 after release.
- Macro undefined: Repeat port absent; a handshake with Pattern=4'b1011 produces exactly one frame 1011, then Done.
